// File: rtl/mem1_if.sv
// mem1 shared types (op codes, mem1->mem2 buffer layout) and the dcache request interface.
// mem1 drives the request through the master modport; the dcache answers with req_ready.
package mem1_pkg;
  typedef logic [7:0] aluop_t;

  localparam aluop_t EXE_NOP_OP   = 8'h00;
  localparam aluop_t EXE_ADD_OP   = 8'h01;
  localparam aluop_t EXE_LD_B_OP  = 8'h20;
  localparam aluop_t EXE_LD_BU_OP = 8'h21;
  localparam aluop_t EXE_LD_H_OP  = 8'h22;
  localparam aluop_t EXE_LD_HU_OP = 8'h23;
  localparam aluop_t EXE_LD_W_OP  = 8'h24;
  localparam aluop_t EXE_LL_OP    = 8'h25;
  localparam aluop_t EXE_ST_B_OP  = 8'h28;
  localparam aluop_t EXE_ST_H_OP  = 8'h29;
  localparam aluop_t EXE_ST_W_OP  = 8'h2a;
  localparam aluop_t EXE_SC_OP    = 8'h2b;

  typedef struct packed {
    aluop_t      aluop;
    logic [31:0] pc;
    logic [31:0] mem_addr;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        excp;
    logic        excp_ale;
  } mem1_mem2_struct;
endpackage

interface mem1_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;

  modport master (
    output req_valid, req_we, req_addr, req_wstrb, req_wdata,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wstrb, req_wdata,
    output req_ready
  );
endinterface

// File: rtl/mem1.sv
// First memory stage: issues the dcache request, tracks the LL/SC link bit, registers the mem2 buffer.
// Optional misaligned-access detection is enabled by defining MEM1_ALE_CHECK_EN.
//
// state  | meaning
// S_IDLE | ready to issue the current ex op
// S_REQ  | request presented but not yet accepted; fields held
// S_DONE | request accepted under downstream stall; waiting for stall release
module mem1
  import mem1_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            llbit_clear,
  input  logic            ex_valid,
  input  aluop_t          ex_aluop,
  input  logic [31:0]     ex_pc,
  input  logic [31:0]     ex_mem_addr,
  input  logic [31:0]     ex_store_data,
  input  logic            ex_wreg,
  input  logic [4:0]      ex_waddr,
  input  logic [31:0]     ex_wdata,
  input  logic            ex_excp,
  mem1_if.master          dcache,
  output logic            stallreq,
  output mem1_mem2_struct mem1_o_buffer
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  state_e          state_q, state_d;
  logic            llbit_q, llbit_d;
  mem1_mem2_struct buf_q, buf_d;
  mem1_mem2_struct load_val;

  logic        is_ld, is_ll, is_st, is_sc, is_mem;
  logic        ale, issue, pending, accept, sc_ok;
  logic        we;
  logic [3:0]  wstrb;
  logic [31:0] wdata;

  always_comb begin
    is_ld = 1'b0;
    is_ll = 1'b0;
    is_st = 1'b0;
    is_sc = 1'b0;
    we    = 1'b0;
    wstrb = 4'b0000;
    wdata = 32'h0;
    case (ex_aluop)
      EXE_LD_B_OP, EXE_LD_BU_OP, EXE_LD_H_OP, EXE_LD_HU_OP, EXE_LD_W_OP: is_ld = 1'b1;
      EXE_LL_OP: is_ll = 1'b1;
      EXE_ST_B_OP: begin
        is_st = 1'b1;
        we    = 1'b1;
        wstrb = 4'b0001 << ex_mem_addr[1:0];
        wdata = {4{ex_store_data[7:0]}};
      end
      EXE_ST_H_OP: begin
        is_st = 1'b1;
        we    = 1'b1;
        wstrb = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{ex_store_data[15:0]}};
      end
      EXE_ST_W_OP: begin
        is_st = 1'b1;
        we    = 1'b1;
        wstrb = 4'b1111;
        wdata = ex_store_data;
      end
      EXE_SC_OP: begin
        is_sc = 1'b1;
        we    = 1'b1;
        wstrb = 4'b1111;
        wdata = ex_store_data;
      end
      default: ;
    endcase
  end

  assign is_mem = is_ld | is_ll | is_st | is_sc;

`ifdef MEM1_ALE_CHECK_EN
  always_comb begin
    ale = 1'b0;
    case (ex_aluop)
      EXE_LD_H_OP, EXE_LD_HU_OP, EXE_ST_H_OP:         ale = ex_mem_addr[0];
      EXE_LD_W_OP, EXE_LL_OP, EXE_ST_W_OP, EXE_SC_OP: ale = (ex_mem_addr[1:0] != 2'b00);
      default:                                        ale = 1'b0;
    endcase
  end
`else
  assign ale = 1'b0;
`endif

  assign issue   = ex_valid & is_mem & ~ex_excp & ~ale & ~(is_sc & ~llbit_q);
  assign pending = issue & (state_q != S_DONE);
  assign accept  = dcache.req_valid & dcache.req_ready;

  // Valid is gated by reset and flush so an outstanding request is withdrawn immediately.
  assign dcache.req_valid = rst & ~flush & pending;
  assign dcache.req_we    = we;
  assign dcache.req_addr  = ex_mem_addr;
  assign dcache.req_wstrb = wstrb;
  assign dcache.req_wdata = wdata;

  assign stallreq = pending & ~dcache.req_ready;

  // In S_DONE the SC has already been accepted (and cleared llbit), so it succeeded.
  assign sc_ok = llbit_q | (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_REQ: begin
          if (!issue)                  state_d = S_IDLE;
          else if (!dcache.req_ready)  state_d = S_REQ;
          else if (stall)              state_d = S_DONE;
          else                         state_d = S_IDLE;
        end
        S_DONE:  if (!stall) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    llbit_d = llbit_q;
    if (accept && is_ll)       llbit_d = 1'b1;
    else if (accept && is_sc)  llbit_d = 1'b0;
    else if (llbit_clear)      llbit_d = 1'b0;
  end

  always_comb begin
    load_val = '0;
    if (ex_valid) begin
      load_val.aluop    = ex_aluop;
      load_val.pc       = ex_pc;
      load_val.mem_addr = ex_mem_addr;
      load_val.wreg     = ex_wreg;
      load_val.waddr    = ex_waddr;
      load_val.wdata    = is_sc ? {31'b0, sc_ok} : ex_wdata;
      load_val.excp     = ex_excp | ale;
      load_val.excp_ale = ale;
    end
    buf_d = buf_q;
    if (flush)       buf_d = '0;
    else if (!stall) buf_d = stallreq ? '0 : load_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      llbit_q <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      llbit_q <= llbit_d;
      buf_q   <= buf_d;
    end
  end

  assign mem1_o_buffer = buf_q;

endmodule

// File: tb/tb_mem1.sv
// Directed self-checking bench for mem1: strobes, ready backpressure, stall-after-accept,
// LL/SC link bit, flush, upstream exceptions, reset mid-request and MEM1_ALE_CHECK_EN.
module tb_mem1;
  import mem1_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall, flush, llbit_clear;
  logic            ex_valid;
  aluop_t          ex_aluop;
  logic [31:0]     ex_pc, ex_mem_addr, ex_store_data, ex_wdata;
  logic            ex_wreg, ex_excp;
  logic [4:0]      ex_waddr;
  logic            stallreq;
  mem1_mem2_struct mb;

  int n_cmp = 0;
  int n_err = 0;

  mem1_if dc_if();

  always #5 clk = ~clk;

  mem1 dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .llbit_clear   (llbit_clear),
    .ex_valid      (ex_valid),
    .ex_aluop      (ex_aluop),
    .ex_pc         (ex_pc),
    .ex_mem_addr   (ex_mem_addr),
    .ex_store_data (ex_store_data),
    .ex_wreg       (ex_wreg),
    .ex_waddr      (ex_waddr),
    .ex_wdata      (ex_wdata),
    .ex_excp       (ex_excp),
    .dcache        (dc_if),
    .stallreq      (stallreq),
    .mem1_o_buffer (mb)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input aluop_t op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [31:0] wd, input logic [31:0] pc);
    ex_valid      = 1'b1;
    ex_aluop      = op;
    ex_mem_addr   = addr;
    ex_store_data = sd;
    ex_wdata      = wd;
    ex_pc         = pc;
    ex_wreg       = 1'b0;
    ex_waddr      = 5'd0;
    ex_excp       = 1'b0;
  endtask

  task automatic idle();
    ex_valid      = 1'b0;
    ex_aluop      = EXE_NOP_OP;
    ex_mem_addr   = 32'h0;
    ex_store_data = 32'h0;
    ex_wdata      = 32'h0;
    ex_pc         = 32'h0;
    ex_wreg       = 1'b0;
    ex_waddr      = 5'd0;
    ex_excp       = 1'b0;
  endtask

  aluop_t      v_op   [6];
  logic [31:0] v_addr [6];
  logic [31:0] v_data [6];
  logic        v_we   [6];
  logic [3:0]  v_strb [6];
  logic [31:0] v_wdat [6];

  initial begin
    v_op   = '{EXE_ST_B_OP, EXE_ST_B_OP, EXE_ST_H_OP, EXE_ST_H_OP, EXE_ST_W_OP, EXE_LD_BU_OP};
    v_addr = '{32'h1003, 32'h1000, 32'h2002, 32'h2000, 32'h3004, 32'h1001};
    v_data = '{32'hAABBCCDD, 32'hAABBCCDD, 32'h12345678, 32'h12345678, 32'hCAFEBABE, 32'h11223344};
    v_we   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    v_strb = '{4'b1000, 4'b0001, 4'b1100, 4'b0011, 4'b1111, 4'b0000};
    v_wdat = '{32'hDDDDDDDD, 32'hDDDDDDDD, 32'h56785678, 32'h56785678, 32'hCAFEBABE, 32'h0};

    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    llbit_clear = 1'b0;
    dc_if.req_ready = 1'b0;
    idle();
    #12;
    check_val("rst_buf", mb, '0);
    check_val("rst_valid", dc_if.req_valid, 1'b0);
    check_val("rst_stallreq", stallreq, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // store/load strobe table, ready always high
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dc_if.req_ready = 1'b1;
      drive(v_op[i], v_addr[i], v_data[i], 32'h0, 32'h100 + i);
      #1;
      check_val("tbl_valid", dc_if.req_valid, 1'b1);
      check_val("tbl_we", dc_if.req_we, v_we[i]);
      check_val("tbl_wstrb", dc_if.req_wstrb, v_strb[i]);
      check_val("tbl_wdata", dc_if.req_wdata, v_wdat[i]);
      check_val("tbl_addr", dc_if.req_addr, v_addr[i]);
      check_val("tbl_stallreq", stallreq, 1'b0);
      @(posedge clk); #1;
      check_val("tbl_buf_addr", mb.mem_addr, v_addr[i]);
      check_val("tbl_buf_op", mb.aluop, v_op[i]);
      check_val("tbl_buf_pc", mb.pc, 32'h100 + i);
    end

    // LD_W with ready low for 3 cycles
    @(negedge clk);
    dc_if.req_ready = 1'b0;
    drive(EXE_LD_W_OP, 32'h3000, 32'h0, 32'h55, 32'h200);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("bp_stallreq", stallreq, 1'b1);
      check_val("bp_valid", dc_if.req_valid, 1'b1);
      check_val("bp_addr", dc_if.req_addr, 32'h3000);
      check_val("bp_wstrb", dc_if.req_wstrb, 4'b0000);
      @(posedge clk); #1;
      check_val("bp_bubble", mb, '0);
      @(negedge clk);
    end
    dc_if.req_ready = 1'b1;
    #1;
    check_val("bp_rel_stallreq", stallreq, 1'b0);
    @(posedge clk); #1;
    check_val("bp_buf_addr", mb.mem_addr, 32'h3000);
    check_val("bp_buf_wdata", mb.wdata, 32'h55);

    // accept while downstream stalled for two cycles
    @(negedge clk);
    stall = 1'b1;
    drive(EXE_LD_W_OP, 32'h4000, 32'h0, 32'h66, 32'h300);
    #1;
    check_val("st_valid_acc", dc_if.req_valid, 1'b1);
    @(posedge clk); #1;
    check_val("st_hold1", mb.mem_addr, 32'h3000);
    @(negedge clk); #1;
    check_val("st_no_reissue", dc_if.req_valid, 1'b0);
    check_val("st_stallreq", stallreq, 1'b0);
    @(posedge clk); #1;
    check_val("st_hold2", mb.mem_addr, 32'h3000);
    @(negedge clk);
    stall = 1'b0;
    #1;
    check_val("st_rel_valid", dc_if.req_valid, 1'b0);
    @(posedge clk); #1;
    check_val("st_load_addr", mb.mem_addr, 32'h4000);
    check_val("st_load_pc", mb.pc, 32'h300);
    @(negedge clk);
    idle();

    // LL then SC succeeds, second SC fails
    @(negedge clk);
    drive(EXE_LL_OP, 32'h5000, 32'h0, 32'h0, 32'h400);
    #1;
    check_val("ll_valid", dc_if.req_valid, 1'b1);
    check_val("ll_we", dc_if.req_we, 1'b0);
    @(negedge clk);
    drive(EXE_SC_OP, 32'h5000, 32'h77, 32'hFFFF, 32'h404);
    #1;
    check_val("sc1_valid", dc_if.req_valid, 1'b1);
    check_val("sc1_wstrb", dc_if.req_wstrb, 4'b1111);
    check_val("sc1_wdata", dc_if.req_wdata, 32'h77);
    @(posedge clk); #1;
    check_val("sc1_buf_wdata", mb.wdata, 32'h1);
    @(negedge clk);
    drive(EXE_SC_OP, 32'h5000, 32'h77, 32'hFFFF, 32'h408);
    #1;
    check_val("sc2_valid", dc_if.req_valid, 1'b0);
    check_val("sc2_stallreq", stallreq, 1'b0);
    @(posedge clk); #1;
    check_val("sc2_buf_wdata", mb.wdata, 32'h0);
    check_val("sc2_buf_op", mb.aluop, EXE_SC_OP);

    // llbit_clear coinciding with LL accept: set wins
    @(negedge clk);
    drive(EXE_LL_OP, 32'h5000, 32'h0, 32'h0, 32'h500);
    llbit_clear = 1'b1;
    @(negedge clk);
    llbit_clear = 1'b0;
    drive(EXE_SC_OP, 32'h5000, 32'h1, 32'h0, 32'h504);
    #1;
    check_val("llclr_win_valid", dc_if.req_valid, 1'b1);
    @(posedge clk); #1;
    check_val("llclr_win_wdata", mb.wdata, 32'h1);

    // llbit_clear alone kills the link
    @(negedge clk);
    drive(EXE_LL_OP, 32'h5000, 32'h0, 32'h0, 32'h600);
    @(negedge clk);
    idle();
    llbit_clear = 1'b1;
    @(negedge clk);
    llbit_clear = 1'b0;
    drive(EXE_SC_OP, 32'h5000, 32'h1, 32'h0, 32'h604);
    #1;
    check_val("llclr_valid", dc_if.req_valid, 1'b0);
    @(posedge clk); #1;
    check_val("llclr_wdata", mb.wdata, 32'h0);

    // flush while in REQ withdraws the request
    @(negedge clk);
    dc_if.req_ready = 1'b0;
    drive(EXE_LD_W_OP, 32'h6000, 32'h0, 32'h9, 32'h700);
    #1;
    check_val("fl_valid_pre", dc_if.req_valid, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check_val("fl_withdraw", dc_if.req_valid, 1'b0);
    @(posedge clk); #1;
    check_val("fl_buf", mb, '0);
    @(negedge clk);
    flush = 1'b0;
    dc_if.req_ready = 1'b1;
    #1;
    check_val("fl_reissue", dc_if.req_valid, 1'b1);
    @(posedge clk); #1;
    check_val("fl_buf_addr", mb.mem_addr, 32'h6000);

    // upstream exception and non-memory op
    @(negedge clk);
    drive(EXE_LD_W_OP, 32'h7000, 32'h0, 32'h0, 32'h800);
    ex_excp = 1'b1;
    #1;
    check_val("excp_valid", dc_if.req_valid, 1'b0);
    @(posedge clk); #1;
    check_val("excp_buf", mb.excp, 1'b1);
    check_val("excp_buf_ale", mb.excp_ale, 1'b0);
    @(negedge clk);
    drive(EXE_ADD_OP, 32'h0, 32'h0, 32'h1234, 32'h804);
    ex_waddr = 5'd5;
    ex_wreg = 1'b1;
    #1;
    check_val("alu_valid", dc_if.req_valid, 1'b0);
    check_val("alu_stallreq", stallreq, 1'b0);
    @(posedge clk); #1;
    check_val("alu_wdata", mb.wdata, 32'h1234);
    check_val("alu_waddr", mb.waddr, 5'd5);

    // misaligned accesses
    @(negedge clk);
    drive(EXE_LD_W_OP, 32'h2, 32'h0, 32'h0, 32'h900);
    #1;
`ifdef MEM1_ALE_CHECK_EN
    check_val("ale_w_valid", dc_if.req_valid, 1'b0);
    @(posedge clk); #1;
    check_val("ale_w_excp", mb.excp, 1'b1);
    check_val("ale_w_ale", mb.excp_ale, 1'b1);
`else
    check_val("ale_w_valid", dc_if.req_valid, 1'b1);
    check_val("ale_w_addr", dc_if.req_addr, 32'h2);
    @(posedge clk); #1;
    check_val("ale_w_excp", mb.excp, 1'b0);
`endif
    @(negedge clk);
    drive(EXE_ST_H_OP, 32'h11, 32'hBEEF, 32'h0, 32'h904);
    #1;
`ifdef MEM1_ALE_CHECK_EN
    check_val("ale_h_valid", dc_if.req_valid, 1'b0);
`else
    check_val("ale_h_valid", dc_if.req_valid, 1'b1);
    check_val("ale_h_wstrb", dc_if.req_wstrb, 4'b0011);
`endif

    // asynchronous reset in the middle of a request
    @(negedge clk);
    dc_if.req_ready = 1'b0;
    drive(EXE_LD_W_OP, 32'h8000, 32'h0, 32'h0, 32'hA00);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_val("arst_valid", dc_if.req_valid, 1'b0);
    check_val("arst_buf", mb, '0);
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1;
    check_val("arst_idle_valid", dc_if.req_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
